// File: rtl/cpu_control_fsm.sv
// Multicycle control unit for the 16-bit CPU datapath.
// It fetches, decodes and sequences one instruction at a time, keeps the status flags and resolves branches.
module cpu_control_fsm #(
    parameter logic [2:0]  RESET_STATE = 3'd0,
    parameter logic [15:0] HALT_WORD   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ram_out,
    input  logic [4:0]  Flags_out,
    output logic [15:0] wEnable,
    output logic [7:0]  opcode,
    output logic [3:0]  Rdest_select,
    output logic [3:0]  Rsrc_select,
    output logic [15:0] Imm_in,
    output logic        Imm_select,
    output logic        fsm_alu_mem_selct,
    output logic        lsc_mux_selct,
    output logic        en_a,
    output logic        ram_we,
    output logic        pc_en,
    output logic        pc_mux_selct,
    output logic [15:0] pc_add_k,
    output logic [4:0]  psr,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WB = 3'd4,
        S_MEM_WR = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ALU_R,
        C_ALU_I,
        C_LOAD,
        C_STOR,
        C_NOP,
        C_BR,
        C_HALT
    } iclass_t;

    state_t      state;
    logic [15:0] ir;
    logic [4:0]  psr_q;
    iclass_t     ir_class;
    logic        is_cmp;
    logic        taken;

    function automatic iclass_t classify(input logic [15:0] w);
        iclass_t c;
        c = C_ALU_I;
        if (w == HALT_WORD) begin
            c = C_HALT;
        end else begin
            case (w[15:12])
                4'b0000: c = C_ALU_R;
                4'b0100: begin
                    case (w[7:4])
                        4'b0000: c = C_LOAD;
                        4'b0100: c = C_STOR;
                        default: c = C_NOP;
                    endcase
                end
                4'b1100: c = C_BR;
                default: c = C_ALU_I;
            endcase
        end
        return c;
    endfunction

    // Branch condition evaluated against the latched flags {C,L,F,Z,N}.
    function automatic logic cond_met(input logic [3:0] cond, input logic [4:0] p);
        logic r;
        case (cond)
            4'b0000: r = p[1];
            4'b0001: r = ~p[1];
            4'b0010: r = p[4];
            4'b0011: r = ~p[4];
            4'b0110: r = p[0];
            4'b1100: r = ~p[0];
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign ir_class = classify(ir);
    assign is_cmp   = ((ir_class == C_ALU_R) && (ir[7:4] == 4'b1011)) ||
                      ((ir_class == C_ALU_I) && (ir[15:12] == 4'b1011));
    assign taken    = cond_met(ir[11:8], psr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= state_t'(RESET_STATE);
            ir    <= '0;
            psr_q <= '0;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    ir <= ram_out;
                    case (classify(ram_out))
                        C_LOAD:  state <= S_MEM_RD;
                        C_STOR:  state <= S_MEM_WR;
                        C_HALT:  state <= S_HALT;
                        default: state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    if ((ir_class == C_ALU_R) || (ir_class == C_ALU_I)) begin
                        psr_q <= Flags_out;
                    end
                    state <= S_FETCH;
                end
                S_MEM_RD: state <= S_MEM_WB;
                S_MEM_WB: state <= S_FETCH;
                S_MEM_WR: state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Moore decode; everything is held at zero while reset is high.
    always_comb begin
        wEnable           = '0;
        opcode            = '0;
        Rdest_select      = '0;
        Rsrc_select       = '0;
        Imm_in            = '0;
        Imm_select        = 1'b0;
        fsm_alu_mem_selct = 1'b0;
        lsc_mux_selct     = 1'b0;
        en_a              = 1'b0;
        ram_we            = 1'b0;
        pc_en             = 1'b0;
        pc_mux_selct      = 1'b0;
        pc_add_k          = '0;
        psr               = '0;
        halted            = 1'b0;
        if (!reset) begin
            psr = psr_q;
            case (state)
                S_FETCH: en_a = 1'b1;
                S_EXEC: begin
                    Rdest_select = ir[11:8];
                    Rsrc_select  = ir[3:0];
                    pc_en        = 1'b1;
                    case (ir_class)
                        C_ALU_R: begin
                            opcode = {4'h0, ir[7:4]};
                            if (!is_cmp) wEnable = 16'h0001 << ir[11:8];
                        end
                        C_ALU_I: begin
                            opcode     = {ir[15:12], 4'h0};
                            Imm_in     = {{8{ir[7]}}, ir[7:0]};
                            Imm_select = 1'b1;
                            if (!is_cmp) wEnable = 16'h0001 << ir[11:8];
                        end
                        C_BR: begin
                            pc_mux_selct = taken;
                            pc_add_k     = {{8{ir[7]}}, ir[7:0]};
                        end
                        default: ;
                    endcase
                end
                S_MEM_RD: begin
                    lsc_mux_selct = 1'b1;
                    Rdest_select  = ir[3:0];
                    en_a          = 1'b1;
                end
                S_MEM_WB: begin
                    fsm_alu_mem_selct = 1'b1;
                    wEnable           = 16'h0001 << ir[11:8];
                    pc_en             = 1'b1;
                end
                S_MEM_WR: begin
                    lsc_mux_selct = 1'b1;
                    Rdest_select  = ir[3:0];
                    Rsrc_select   = ir[11:8];
                    en_a          = 1'b1;
                    ram_we        = 1'b1;
                    pc_en         = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: a reference model queues the expected per-cycle outputs of
// each issued instruction, and a negedge monitor compares them against the DUT.
module tb_cpu_control_fsm;

    typedef struct packed {
        logic [15:0] wen;
        logic [7:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
        logic        imm_sel;
        logic        wb_sel;
        logic        lsc;
        logic        en_a;
        logic        we;
        logic        pc_en;
        logic        pc_sel;
        logic [15:0] k;
        logic [4:0]  psr;
        logic        halted;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] ram_out = '0;
    logic [4:0]  Flags_out = '0;
    logic [15:0] wEnable, Imm_in, pc_add_k;
    logic [7:0]  opcode;
    logic [3:0]  Rdest_select, Rsrc_select;
    logic        Imm_select, fsm_alu_mem_selct, lsc_mux_selct, en_a, ram_we, pc_en, pc_mux_selct, halted;
    logic [4:0]  psr;

    vec_t        exp_q[$];
    string       tag_q[$];
    logic [15:0] fetch_word = '0;
    logic [4:0]  m_psr = '0;
    bit          started = 1'b0;
    int          checks = 0;
    int          errors = 0;

    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .ram_out(ram_out), .Flags_out(Flags_out),
        .wEnable(wEnable), .opcode(opcode), .Rdest_select(Rdest_select), .Rsrc_select(Rsrc_select),
        .Imm_in(Imm_in), .Imm_select(Imm_select), .fsm_alu_mem_selct(fsm_alu_mem_selct),
        .lsc_mux_selct(lsc_mux_selct), .en_a(en_a), .ram_we(ram_we), .pc_en(pc_en),
        .pc_mux_selct(pc_mux_selct), .pc_add_k(pc_add_k), .psr(psr), .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM stand-in: instruction on a PC fetch, random data on a register read.
    always @(negedge clk) begin
        if (en_a && !lsc_mux_selct) ram_out = fetch_word;
        else if (en_a && lsc_mux_selct && !ram_we) ram_out = 16'($urandom);
    end

    always @(negedge clk) begin
        vec_t a, e;
        string t;
        a = '0;
        a.wen = wEnable;      a.op = opcode;           a.rd = Rdest_select;  a.rs = Rsrc_select;
        a.imm = Imm_in;       a.imm_sel = Imm_select;  a.wb_sel = fsm_alu_mem_selct;
        a.lsc = lsc_mux_selct; a.en_a = en_a;          a.we = ram_we;        a.pc_en = pc_en;
        a.pc_sel = pc_mux_selct; a.k = pc_add_k;       a.psr = psr;          a.halted = halted;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", t, a, e);
            end
        end else if (started) begin
            checks++;
            errors++;
            $display("FAIL idle: output %h with no expectation queued", a);
        end
    end

    function automatic bit br_taken(input logic [3:0] c, input logic [4:0] p);
        case (c)
            4'd0:    return p[1];
            4'd1:    return !p[1];
            4'd2:    return p[4];
            4'd3:    return !p[4];
            4'd6:    return p[0];
            4'd12:   return !p[0];
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input vec_t v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    // Must be entered #1 after the rising edge that starts the instruction's fetch cycle.
    task automatic issue(input logic [15:0] w, input logic [4:0] f, input bit rst_exec);
        vec_t        v;
        int          n, rst_at;
        logic [3:0]  op, ext;
        logic [15:0] onehot, sx;
        bit          is_halt, is_load, is_stor, is_br, is_alu, is_cmp;
        op      = w[15:12];
        ext     = w[7:4];
        onehot  = 16'h0001 << w[11:8];
        sx      = {{8{w[7]}}, w[7:0]};
        is_halt = (w == 16'hFFFF);
        is_load = (op == 4'h4) && (ext == 4'h0);
        is_stor = (op == 4'h4) && (ext == 4'h4);
        is_br   = (op == 4'hC);
        is_alu  = !is_halt && (op != 4'h4) && !is_br;
        is_cmp  = ((op == 4'h0) && (ext == 4'hB)) || (op == 4'hB);
        reset = 1'b0;
        Flags_out = f;
        fetch_word = w;
        rst_at = -1;
        v = '0; v.en_a = 1'b1; v.psr = m_psr; push(v, "fetch");
        v = '0; v.psr = m_psr; push(v, "decode");
        n = 2;
        if (is_halt) begin
            for (int i = 0; i < 3; i++) begin
                v = '0; v.halted = 1'b1; v.psr = m_psr; push(v, "halt");
            end
            v = '0; push(v, "halt_reset");
            rst_at = 5; n = 6; m_psr = '0;
        end else if (is_load) begin
            v = '0; v.psr = m_psr; v.lsc = 1'b1; v.rd = w[3:0]; v.en_a = 1'b1; push(v, "load_rd");
            v = '0; v.psr = m_psr; v.wb_sel = 1'b1; v.wen = onehot; v.pc_en = 1'b1; push(v, "load_wb");
            n = 4;
        end else if (is_stor) begin
            v = '0; v.psr = m_psr; v.lsc = 1'b1; v.rd = w[3:0]; v.rs = w[11:8];
            v.en_a = 1'b1; v.we = 1'b1; v.pc_en = 1'b1; push(v, "store");
            n = 3;
        end else if (rst_exec) begin
            v = '0; push(v, "exec_reset");
            rst_at = 2; n = 3; m_psr = '0;
        end else begin
            v = '0; v.psr = m_psr; v.rd = w[11:8]; v.rs = w[3:0]; v.pc_en = 1'b1;
            if (is_alu && op == 4'h0) begin
                v.op = {4'h0, ext};
                v.wen = is_cmp ? 16'h0 : onehot;
            end else if (is_alu) begin
                v.op = {op, 4'h0};
                v.imm = sx;
                v.imm_sel = 1'b1;
                v.wen = is_cmp ? 16'h0 : onehot;
            end else if (is_br) begin
                v.pc_sel = br_taken(w[11:8], m_psr);
                v.k = sx;
            end
            push(v, is_br ? "branch" : (is_alu ? "alu" : "nop"));
            if (is_alu) m_psr = f;
            n = 3;
        end
        for (int i = 0; i < n; i++) begin
            reset = (i == rst_at);
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0]  op, ext;
        logic [15:0] w;
        ext = 4'($urandom);
        case ($urandom_range(0, 5))
            0: w = {4'h0, 4'($urandom), ext, 4'($urandom)};
            1: begin
                op = 4'($urandom);
                if (op == 4'h0 || op == 4'h4 || op == 4'hC) op = 4'hB;
                w = {op, 4'($urandom), 8'($urandom)};
                if (w == 16'hFFFF) w = 16'hFFFE;
            end
            2: w = {4'h4, 4'($urandom), 4'h0, 4'($urandom)};
            3: w = {4'h4, 4'($urandom), 4'h4, 4'($urandom)};
            4: begin
                if (ext == 4'h0 || ext == 4'h4) ext = 4'h7;
                w = {4'h4, 4'($urandom), ext, 4'($urandom)};
            end
            default: w = {4'hC, 4'($urandom), 8'($urandom)};
        endcase
        return w;
    endfunction

    initial begin
        reset = 1'b1;
        @(posedge clk); #1;
        started = 1'b1;
        push('0, "reset0");
        push('0, "reset1");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_psr = '0;

        issue(16'h0153, 5'h00, 1'b0);
        issue(16'h52FF, 5'h15, 1'b0);
        issue(16'h4406, 5'h03, 1'b0);
        issue(16'h4547, 5'h08, 1'b0);
        issue(16'h0120, 5'b00010, 1'b0);
        issue(16'hC0FC, 5'h00, 1'b0);
        issue(16'h0120, 5'b00000, 1'b0);
        issue(16'hC0FC, 5'h00, 1'b0);
        issue(16'hB105, 5'h1F, 1'b0);
        issue(16'h02B3, 5'h0A, 1'b0);
        issue(16'hE1E4, 5'h11, 1'b0);
        issue(16'hFFFF, 5'h00, 1'b0);
        issue(16'h0153, 5'h1F, 1'b0);
        issue(16'h0153, 5'h07, 1'b1);
        issue(16'hCEF0, 5'h00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            issue(rand_instr(), 5'($urandom), 1'b0);
        end
        issue(16'hFFFF, 5'h00, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        started = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multicycle control unit that sequences the 16-bit CPU datapath (register bank, ALU, RAM, PC) one instruction at a time.
- Fetches from RAM at PC, latches the instruction, and decodes it.
- Drives every datapath select, enable and write strobe per state; keeps the processor status flags.
- Resolves conditional branches.

Parameters:
- RESET_STATE, 3'd0, state entered on reset (S_FETCH).
- HALT_WORD, 16'hFFFF, instruction encoding that halts the core.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- ram_out  in  16  RAM port-A read data (instruction or load data).
- Flags_out  in  5  ALU flags {C,L,F,Z,N}.
- wEnable  out  16  one-hot register-bank write enable.
- opcode  out  8  ALU operation.
- Rdest_select  out  4  Rdest mux select.
- Rsrc_select  out  4  Rsrc mux select.
- Imm_in  out  16  sign-extended immediate.
- Imm_select  out  1  1 = immediate into ALU B.
- fsm_alu_mem_selct  out  1  writeback source: 0 = ALU, 1 = RAM.
- lsc_mux_selct  out  1  RAM address source: 0 = PC, 1 = register.
- en_a  out  1  RAM port-A enable.
- ram_we  out  1  RAM write strobe.
- pc_en  out  1  PC load, one cycle per instruction.
- pc_mux_selct  out  1  0 = PC+1, 1 = PC+pc_add_k.
- pc_add_k  out  16  sign-extended branch displacement.
- psr  out  5  latched status flags.
- halted  out  1  core stopped.

Behaviour:
- Reset: the reset cycle forces S_FETCH, ir=0, psr=0. All outputs are 0 while reset is high, including en_a. A reset mid-instruction abandons it: no wEnable, ram_we or pc_en is asserted in the reset cycle.
- Internal regs: state[2:0], ir[15:0], psr[4:0]. Outputs are Moore, decoded from state and ir.
- Decode classes:
  - ALU-R: ir[15:12]=0000, opcode={4'h0,ir[7:4]}.
  - MEM: ir[15:12]=0100; ext ir[7:4]=0000 is LOAD, 0100 is STOR, any other ext is NOP.
  - BR: ir[15:12]=1100, cond=ir[11:8], disp=ir[7:0].
  - HALT: ir==HALT_WORD.
  - ALU-I: all other ops, opcode={ir[15:12],4'h0}, Imm_in=sign-extended ir[7:0], Imm_select=1.
  - CMP (R ext 1011) and CMPI (op 1011): flags only, wEnable stays 0.
- S_FETCH: lsc_mux_selct=0, en_a=1. RAM is a synchronous read, so data is valid next cycle. Next state S_DECODE.
- S_DECODE: ir<=ram_out. Next state from ram_out class: ALU/BR to S_EXEC, LOAD to S_MEM_RD, STOR to S_MEM_WR, HALT to S_HALT, NOP to S_EXEC with no writeback.
- S_EXEC:
  - Rdest_select=ir[11:8], Rsrc_select=ir[3:0].
  - ALU class: wEnable=1<<ir[11:8] (0 for CMP/CMPI), psr<=Flags_out.
  - pc_en=1. For BR, pc_mux_selct=taken and pc_add_k=sign-extended disp.
  - Next state S_FETCH.
- Branch conditions (Z=psr[1], N=psr[0], C=psr[4]):
  - 0000 EQ: Z.
  - 0001 NE: !Z.
  - 0010 CS: C.
  - 0011 CC: !C.
  - 0110 GT: N.
  - 1100 LE: !N.
  - 1110 UC: 1.
  - Any other cond: not taken.
- S_MEM_RD: lsc_mux_selct=1, Rdest_select=ir[3:0] (address register), en_a=1. Next state S_MEM_WB.
- S_MEM_WB: fsm_alu_mem_selct=1, wEnable=1<<ir[11:8], pc_en=1, pc_mux_selct=0. Next state S_FETCH.
- S_MEM_WR: lsc_mux_selct=1, Rdest_select=ir[3:0], Rsrc_select=ir[11:8] (store data), en_a=1, ram_we=1 for exactly one cycle, pc_en=1. Next state S_FETCH.
- S_HALT: halted=1, all strobes 0, stays until reset.
- Latency per instruction:
  - ALU, BR, NOP: 3 cycles.
  - STOR: 3 cycles.
  - LOAD: 4 cycles.
- Invariants:
  - Exactly one pc_en pulse per instruction (none for HALT).
  - wEnable is never multi-hot.
  - ram_we and a nonzero wEnable are never asserted in the same cycle.
  - psr changes only in S_EXEC of ALU-class instructions.
  - Undefined state encodings return to S_FETCH.

Test Plan:
- Reset held 2 cycles, then released with RAM[0]=16'h0153 (R1=R1+R3 form): all outputs 0 during reset; cycle 1 en_a=1, lsc=0; cycle 3 wEnable=16'h0002, opcode=8'h05, pc_en=1.
- ADDI R2,#-1 (16'h52FF): Imm_select=1, Imm_in=16'hFFFF, wEnable=16'h0004; psr is updated from the Flags_out value presented in that cycle.
- LOAD R4,[R6] (16'h4406): lsc=1 and Rdest_select=6 in S_MEM_RD; next cycle fsm_alu_mem_selct=1, wEnable=16'h0010. Total 4 cycles.
- STOR R5,[R7] (16'h4547): ram_we=1 for exactly one cycle, Rdest_select=7, Rsrc_select=5, wEnable=0.
- BEQ -4 (16'hC0FC) with psr Z=1: pc_mux_selct=1, pc_add_k=16'hFFFC. Repeat with Z=0: pc_mux_selct=0.
- HALT (16'hFFFF) then reset asserted mid-S_EXEC of a following test: halted=1 and no pc_en in the halt case; in the mid-EXEC case, reset forces wEnable=0 that cycle and the core is in S_FETCH next cycle.
